fft_sched: RTL and testbench
============================

FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 Parameter LOG2N, default 4, log2 of FFT length N (N = 2^LOG2N points, N/2 butterflies per stage, LOG2N stages).
REQ-002 Parameter BFLY_LAT, default 2, cycles from butterfly operand read (rd_en) to result write (wr_en); legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to run one in-place FFT over sample memory.
REQ-006 stall  input  1  memory/butterfly not ready; freezes the block.
REQ-007 busy  output  1  high while a transform is in progress.
REQ-008 done  output  1  one-cycle pulse on completion.
REQ-009 rd_en  output  1  operand pair read strobe.
REQ-010 rd_addr_a, rd_addr_b  output  LOG2N each  operand A/B sample addresses.
REQ-011 tw_addr  output  LOG2N-1  twiddle ROM index, aligned with rd_en.
REQ-012 wr_en  output  1  result pair write strobe.
REQ-013 wr_addr_a, wr_addr_b  output  LOG2N each  result A/B write addresses.
REQ-014 stage  output  clog2(LOG2N)  current stage index, for scaling control.

Function
REQ-015 Sample words are 32-bit {real[31:16], imag[15:0]}, signed 16-bit, 6 fractional bits; fft_sched only generates addresses, never touches data.
REQ-016 FSM states IDLE, ISSUE, DRAIN, DONE; IDLE->ISSUE on start; ISSUE->DRAIN after butterfly N/2-1 issued; DRAIN->ISSUE (next stage) or ->DONE (last stage) after BFLY_LAT unstalled cycles; DONE->IDLE after one cycle.
REQ-017 start is sampled only in IDLE; start while busy is ignored.
REQ-018 In ISSUE, one butterfly j (0..N/2-1) per unstalled cycle, rd_en=1; for stage s: half=2^s, k=j mod half, rd_addr_a=(j>>s)*2*half+k, rd_addr_b=rd_addr_a+half, tw_addr=k<<(LOG2N-1-s) (DIT, bit-reversed input order in memory).
REQ-019 wr_en/wr_addr_a/wr_addr_b equal rd_en/rd_addr_a/rd_addr_b delayed by exactly BFLY_LAT unstalled cycles (valid-tagged delay line).
REQ-020 DRAIN issues no reads, guaranteeing every write of stage s precedes any read of stage s+1 (no RAW hazard).
REQ-021 stall=1 forces rd_en=0 and wr_en=0, freezes FSM, counters and delay line; release resumes with no lost or duplicated butterfly.
REQ-022 busy=1 from the cycle after start is accepted through the last DRAIN cycle; done=1 in DONE only; busy=0 in DONE.
REQ-023 Unstalled latency start-accept to done = LOG2N*(N/2+BFLY_LAT)+1 cycles (41 for defaults).
REQ-024 Address arithmetic is modulo N; j counter wraps to 0 and stage increments at DRAIN exit.

Reset
REQ-025 rst_n low asynchronously forces IDLE, busy=0, done=0, rd_en=0, wr_en=0, all addresses/tw_addr/stage=0, delay-line valids cleared.
REQ-026 Reset mid-transform aborts it with no further wr_en; a new start after release begins at stage 0, j=0.

Structure
REQ-027 Shared package fft_pkg holds sample word constants (WORD_SZ=32, WORD_MID=16, FRAC_BITS=6), the FSM state enum, and the address-generation function.
REQ-028 One sub-module, fft_delay_line (parameterised width/depth, stall-gated), implements REQ-019.

Verification
REQ-029 Defaults, start at cycle 0, no stall -> rd_en cycles 1-8, 11-18, 21-28, 31-38; done single pulse cycle 41; busy high 1-40.
REQ-030 Address check -> s0 j0: a=0,b=1,tw=0; s1 j1: a=1,b=3,tw=4; s2 j5: a=9,b=13,tw=2; s3 j7: a=7,b=15,tw=7.
REQ-031 Write-back check -> every wr_en 2 cycles after its rd_en with identical a/b; each address 0-15 written exactly once per stage.
REQ-032 stall high cycles 5-7 -> no rd_en/wr_en there, sequence resumes at j=4 cycle 8, done slips to cycle 44.
REQ-033 start pulsed again at cycle 10 -> ignored, single done at cycle 41.
REQ-034 rst_n low at cycle 20 -> all outputs 0 immediately, no wr_en after; start at cycle 25 -> reads s0 j0 (a=0,b=1) at cycle 26.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the FFT address scheduler.
//   WORD_SZ/WORD_MID/FRAC_BITS : sample word layout {real[31:16], imag[15:0]},
//                                signed 16-bit, 6 fractional bits.
//   fft_state_t                : scheduler FSM states.
//   bfly_addr()                : radix-2 DIT butterfly operand/twiddle addresses.
package fft_pkg;

    localparam int WORD_SZ   = 32;
    localparam int WORD_MID  = 16;
    localparam int FRAC_BITS = 6;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fft_state_t;

    // Fields are wide enough for any practical LOG2N; callers truncate.
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] tw;
    } bfly_addr_t;

    // Butterfly j of stage s: pairs sit 2^s apart inside blocks of 2^(s+1)
    // points; the twiddle index steps by N/2^(s+1).
    function automatic bfly_addr_t bfly_addr(input int unsigned log2n,
                                             input int unsigned s,
                                             input int unsigned j);
        int unsigned half;
        int unsigned k;
        int unsigned a;
        int unsigned mask;
        bfly_addr_t  r;
        half = 32'd1 << s;
        k    = j & (half - 32'd1);
        a    = ((j >> s) << (s + 32'd1)) | k;
        mask = (32'd1 << log2n) - 32'd1;
        r.a  = 16'(a & mask);
        r.b  = 16'((a + half) & mask);
        r.tw = 16'(k << (log2n - 32'd1 - s));
        return r;
    endfunction

endpackage

// File: rtl/fft_sched_if.sv
// fft_sched_if -- control/address bundle between the FFT scheduler and the
// sample memory / butterfly datapath.
//   master (scheduler): in  start, stall
//                       out busy, done, rd_en, rd_addr_a/b, tw_addr,
//                           wr_en, wr_addr_a/b, stage
//   slave  (datapath) : mirror image of master.
interface fft_sched_if #(
    parameter int LOG2N = 4
);
    localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    logic             start;
    logic             stall;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [STG_W-1:0] stage;

    modport master (
        input  start, stall,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );

    modport slave (
        output start, stall,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage
    );

endinterface

// File: rtl/fft_delay_line.sv
// fft_delay_line -- valid-tagged shift register, DEPTH stages deep, advancing
// only while en is high.
//   clk, rst_n          : clock, async active-low reset (clears valids and data)
//   en                  : shift enable (low freezes every stage)
//   in_valid, in_data   : entry captured on an enabled edge
//   out_valid, out_data : entry captured DEPTH enabled edges earlier
module fft_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/fft_sched.sv
// fft_sched -- address scheduler for an in-place radix-2 DIT FFT over N=2^LOG2N
// points (bit-reversed input order in memory). Issues one butterfly read per
// unstalled cycle, replays each read as a write BFLY_LAT unstalled cycles
// later, and drains between stages so no stage reads data still in flight.
//   clk, rst_n : clock, async active-low reset
//   bus        : fft_sched_if.master (start/stall in; busy, done, read/write
//                strobes and addresses, twiddle index, stage out)
module fft_sched
    import fft_pkg::*;
#(
    parameter int LOG2N    = 4,
    parameter int BFLY_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    fft_sched_if.master bus
);

    localparam int AW    = LOG2N;
    localparam int TW_W  = LOG2N - 1;
    localparam int JW    = LOG2N - 1;
    localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    fft_state_t       state_q;
    logic [JW-1:0]    j_q;
    logic [STG_W-1:0] stage_q;
    logic [3:0]       drain_q;
    logic             rd_q;
    logic             busy_q;
    logic             done_q;
    logic [AW-1:0]    ra_q;
    logic [AW-1:0]    rb_q;
    logic [TW_W-1:0]  tw_q;

    bfly_addr_t       ad_first;
    bfly_addr_t       ad_next_j;
    bfly_addr_t       ad_next_stg;

    logic             rd_fire;
    logic             dl_valid;
    logic [2*AW-1:0]  dl_data;

    // Address registers hold the butterfly presented this cycle, so the
    // follow-on addresses are precomputed for each possible successor.
    always_comb begin
        ad_first    = bfly_addr(LOG2N, 0, 0);
        ad_next_j   = bfly_addr(LOG2N, 32'(stage_q), 32'(j_q) + 32'd1);
        ad_next_stg = bfly_addr(LOG2N, 32'(stage_q) + 32'd1, 0);
    end

    // stall freezes everything, including the IDLE start sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
            rd_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
        end else if (!bus.stall) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                        rd_q    <= 1'b1;
                        j_q     <= '0;
                        stage_q <= '0;
                        ra_q    <= AW'(ad_first.a);
                        rb_q    <= AW'(ad_first.b);
                        tw_q    <= TW_W'(ad_first.tw);
                    end
                end
                ISSUE: begin
                    if (j_q == '1) begin
                        state_q <= DRAIN;
                        rd_q    <= 1'b0;
                        drain_q <= '0;
                    end else begin
                        j_q  <= j_q + 1'b1;
                        ra_q <= AW'(ad_next_j.a);
                        rb_q <= AW'(ad_next_j.b);
                        tw_q <= TW_W'(ad_next_j.tw);
                    end
                end
                DRAIN: begin
                    if (drain_q == 4'(BFLY_LAT - 1)) begin
                        j_q <= '0;
                        if (stage_q == STG_W'(LOG2N - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ISSUE;
                            stage_q <= stage_q + 1'b1;
                            rd_q    <= 1'b1;
                            ra_q    <= AW'(ad_next_stg.a);
                            rb_q    <= AW'(ad_next_stg.b);
                            tw_q    <= TW_W'(ad_next_stg.tw);
                        end
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    stage_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A read presented during a stalled cycle is not consumed; it stays in
    // the registers and is re-presented once stall drops.
    assign rd_fire = rd_q & ~bus.stall;

    fft_delay_line #(
        .WIDTH(2 * AW),
        .DEPTH(BFLY_LAT)
    ) u_wr_dly (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (~bus.stall),
        .in_valid (rd_fire),
        .in_data  ({ra_q, rb_q}),
        .out_valid(dl_valid),
        .out_data (dl_data)
    );

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_fire;
    assign bus.rd_addr_a = ra_q;
    assign bus.rd_addr_b = rb_q;
    assign bus.tw_addr   = tw_q;
    assign bus.stage     = stage_q;
    assign bus.wr_en     = dl_valid & ~bus.stall;
    assign bus.wr_addr_a = dl_data[2*AW-1:AW];
    assign bus.wr_addr_b = dl_data[AW-1:0];

endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched -- self-checking bench for fft_sched. A progress-counter model
// (stage/butterfly/latency derived from elapsed unstalled cycles) is compared
// against the DUT on every falling edge; directed runs pin the model with
// hand-derived cycle maps and addresses, then a randomized run follows.
module tb_fft_sched;

    localparam int LOG2N    = 4;
    localparam int BFLY_LAT = 2;
    localparam int N        = 1 << LOG2N;
    localparam int NH       = N / 2;
    localparam int PER      = NH + BFLY_LAT;
    localparam int T        = LOG2N * PER + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fft_sched_if #(.LOG2N(LOG2N)) bus ();

    fft_sched #(
        .LOG2N   (LOG2N),
        .BFLY_LAT(BFLY_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base  = -100000;

    logic [127:0] rd_vec, wr_vec, busy_vec, done_vec, any_vec;
    int rec_a [128];
    int rec_b [128];
    int rec_tw [128];
    int rec_wa [128];
    int rec_wb [128];
    int rec_stage [128];

    bit m_active = 1'b0;
    int m_u      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_addr_a(input int s, input int j);
        int half;
        half = 1 << s;
        return (j / half) * 2 * half + (j % half);
    endfunction

    function automatic int m_tw(input int s, input int j);
        int half;
        half = 1 << s;
        return (j % half) * (N / (2 * half));
    endfunction

    // Unstalled progress index u (1 = first cycle after accept): each stage
    // is NH read cycles followed by BFLY_LAT drain cycles.
    function automatic bit m_rd_slot(input int u);
        return (u >= 1) && (u <= T - 1) && (((u - 1) % PER) < NH);
    endfunction

    function automatic logic [127:0] span(input int lo, input int hi);
        logic [127:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    int rel, uw, es, ej, ews, ewj;
    bit e_rd, e_wr, e_busy, e_done;
    logic [24:0] outs;

    always @(negedge clk) begin
        outs = {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b,
                bus.wr_addr_a, bus.wr_addr_b, bus.tw_addr, bus.stage};
        rel = cyc - base;
        if (rel >= 0 && rel < 128) begin
            rd_vec[rel]    = bus.rd_en;
            wr_vec[rel]    = bus.wr_en;
            busy_vec[rel]  = bus.busy;
            done_vec[rel]  = bus.done;
            any_vec[rel]   = |outs;
            rec_a[rel]     = int'(bus.rd_addr_a);
            rec_b[rel]     = int'(bus.rd_addr_b);
            rec_tw[rel]    = int'(bus.tw_addr);
            rec_wa[rel]    = int'(bus.wr_addr_a);
            rec_wb[rel]    = int'(bus.wr_addr_b);
            rec_stage[rel] = int'(bus.stage);
        end
        if (!rst_n) begin
            m_active = 1'b0;
            chk("reset_outputs", 128'(outs), '0);
        end else begin
            e_busy = m_active && (m_u <= T - 1);
            e_done = m_active && (m_u == T);
            e_rd   = m_active && !bus.stall && m_rd_slot(m_u);
            uw     = m_u - BFLY_LAT;
            e_wr   = m_active && !bus.stall && m_rd_slot(uw);
            es     = (m_u - 1) / PER;
            ej     = (m_u - 1) % PER;
            ews    = (uw - 1) / PER;
            ewj    = (uw - 1) % PER;
            chk("busy", 128'(bus.busy), 128'(e_busy));
            chk("done", 128'(bus.done), 128'(e_done));
            chk("rd_en", 128'(bus.rd_en), 128'(e_rd));
            chk("wr_en", 128'(bus.wr_en), 128'(e_wr));
            if (e_busy) chk("stage", 128'(bus.stage), 128'(es));
            if (e_rd) begin
                chk("rd_addr_a", 128'(bus.rd_addr_a), 128'(m_addr_a(es, ej)));
                chk("rd_addr_b", 128'(bus.rd_addr_b), 128'(m_addr_a(es, ej) + (1 << es)));
                chk("tw_addr", 128'(bus.tw_addr), 128'(m_tw(es, ej)));
            end
            if (e_wr) begin
                chk("wr_addr_a", 128'(bus.wr_addr_a), 128'(m_addr_a(ews, ewj)));
                chk("wr_addr_b", 128'(bus.wr_addr_b), 128'(m_addr_a(ews, ewj) + (1 << ews)));
            end
            if (!bus.stall) begin
                if (m_active) begin
                    if (m_u == T) m_active = 1'b0;
                    else m_u = m_u + 1;
                end else if (bus.start) begin
                    m_active = 1'b1;
                    m_u      = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Relative cycle 0 is the period in which start is first driven high.
    task automatic run_case(input int st_lo, input int st_hi, input int again,
                            input int rst_at, input int len);
        rd_vec = '0; wr_vec = '0; busy_vec = '0; done_vec = '0; any_vec = '0;
        for (int i = 0; i < 128; i++) begin
            rec_a[i] = 0; rec_b[i] = 0; rec_tw[i] = 0;
            rec_wa[i] = 0; rec_wb[i] = 0; rec_stage[i] = 0;
        end
        base = cyc;
        for (int r = 0; r < len; r++) begin
            bus.start = (r == 0) || (r == again) || (rst_at >= 0 && r == rst_at + 5);
            bus.stall = (r >= st_lo) && (r <= st_hi);
            rst_n     = !(rst_at >= 0 && r >= rst_at && r < rst_at + 2);
            step();
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst_n     = 1'b1;
    endtask

    int cnt [N];
    int bad;

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // A: plain run
        run_case(-1, -1, -1, -1, 50);
        chk("A_rd_cycles", rd_vec, span(1, 8) | span(11, 18) | span(21, 28) | span(31, 38));
        chk("A_wr_cycles", wr_vec, span(3, 10) | span(13, 20) | span(23, 30) | span(33, 40));
        chk("A_busy_cycles", busy_vec, span(1, 40));
        chk("A_done_cycles", done_vec, span(41, 41));
        chk("A_s0j0_a", 128'(rec_a[1]), 128'(0));
        chk("A_s0j0_b", 128'(rec_b[1]), 128'(1));
        chk("A_s0j0_tw", 128'(rec_tw[1]), 128'(0));
        chk("A_s1j1_a", 128'(rec_a[12]), 128'(1));
        chk("A_s1j1_b", 128'(rec_b[12]), 128'(3));
        chk("A_s1j1_tw", 128'(rec_tw[12]), 128'(4));
        chk("A_s2j5_a", 128'(rec_a[26]), 128'(9));
        chk("A_s2j5_b", 128'(rec_b[26]), 128'(13));
        chk("A_s2j5_tw", 128'(rec_tw[26]), 128'(2));
        chk("A_s3j7_a", 128'(rec_a[38]), 128'(7));
        chk("A_s3j7_b", 128'(rec_b[38]), 128'(15));
        chk("A_s3j7_tw", 128'(rec_tw[38]), 128'(7));
        chk("A_s3_stage", 128'(rec_stage[38]), 128'(3));
        for (int s = 0; s < LOG2N; s++) begin
            for (int a = 0; a < N; a++) cnt[a] = 0;
            for (int r = 3 + 10 * s; r <= 10 + 10 * s; r++) begin
                if (wr_vec[r]) begin
                    cnt[rec_wa[r]]++;
                    cnt[rec_wb[r]]++;
                end
            end
            bad = 0;
            for (int a = 0; a < N; a++) if (cnt[a] != 1) bad++;
            chk($sformatf("A_write_once_s%0d", s), 128'(bad), 128'(0));
        end

        // B: stall during cycles 5..7
        run_case(5, 7, -1, -1, 55);
        chk("B_rd_cycles", rd_vec,
            span(1, 4) | span(8, 11) | span(14, 21) | span(24, 31) | span(34, 41));
        chk("B_wr_cycles", wr_vec,
            span(3, 4) | span(8, 13) | span(16, 23) | span(26, 33) | span(36, 43));
        chk("B_busy_cycles", busy_vec, span(1, 43));
        chk("B_done_cycles", done_vec, span(44, 44));
        chk("B_resume_a", 128'(rec_a[8]), 128'(8));
        chk("B_resume_b", 128'(rec_b[8]), 128'(9));

        // C: second start while busy
        run_case(-1, -1, 10, -1, 50);
        chk("C_done_cycles", done_vec, span(41, 41));
        chk("C_rd_cycles", rd_vec, span(1, 8) | span(11, 18) | span(21, 28) | span(31, 38));

        // D: reset at cycle 20, restart at 25
        run_case(-1, -1, -1, 20, 75);
        chk("D_outputs_in_reset", 128'(any_vec[20]), 128'(0));
        chk("D_no_wr_after_reset", wr_vec & span(20, 25), '0);
        chk("D_rd_restart", rd_vec & span(19, 26), span(26, 26));
        chk("D_restart_a", 128'(rec_a[26]), 128'(0));
        chk("D_restart_b", 128'(rec_b[26]), 128'(1));
        chk("D_done_cycles", done_vec, span(66, 66));

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            rst_n     = ($urandom_range(0, 599) != 0);
            step();
        end
        bus.start = 1'b0;
        bus.stall = 1'b0;
        rst_n     = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
